// File: rtl/sc_sequencer_if.sv
// Instruction-memory fetch port of the Simple Computer sequencer.
// The master side issues req/addr and the slave (memory) returns ack/data.
interface sc_sequencer_if #(
   parameter int ADDR_W = 16
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [15:0]       imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data
   );
endinterface

// File: rtl/sc_sequencer.sv
// Fetch/execute sequencer: owns PC and IR, fetches over a req/ack port, strobes execute.
// Optional HALT on 16'hFFFF is enabled by defining the SC_HALT_EN macro.
module sc_sequencer #(
   parameter int               ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   sc_sequencer_if.master      imem,
   output logic [15:0]         o_ir,
   input  logic                i_pl,
   input  logic                i_jb,
   input  logic                i_bc,
   input  logic                i_n,
   input  logic                i_z,
   input  logic [ADDR_W-1:0]   i_a_bus,
   output logic                o_exec_en,
   output logic [ADDR_W-1:0]   o_pc,
   output logic                o_halted
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_pc;
   logic [15:0]       r_ir;
   logic              w_ir_load;
   logic              w_pc_load;
   logic              w_taken;
   logic [ADDR_W-1:0] w_offset;
   logic [ADDR_W-1:0] w_pc_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_ir    <= 16'h0000;
      end else begin
         r_state <= w_state_next;
         if (w_ir_load) r_ir <= imem.imem_data;
         if (w_pc_load) r_pc <= w_pc_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_ir_load    = 1'b0;
      w_pc_load    = 1'b0;
      case (r_state)
         S_IDLE:  w_state_next = S_FETCH;
         S_FETCH: begin
            if (imem.imem_ack) begin
               w_ir_load    = 1'b1;
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
`ifdef SC_HALT_EN
            if (r_ir == 16'hFFFF) begin
               w_state_next = S_HALT;
            end else begin
               w_pc_load    = 1'b1;
               w_state_next = S_FETCH;
            end
`else
            w_pc_load    = 1'b1;
            w_state_next = S_FETCH;
`endif
         end
`ifdef SC_HALT_EN
         S_HALT:  w_state_next = S_HALT;
`endif
         default: w_state_next = S_IDLE;
      endcase
   end

   // Branch displacement is split across ir[8:6] and ir[2:0], relative to the branch itself.
   always_comb begin
      w_taken  = i_bc ? i_n : i_z;
      w_offset = {{(ADDR_W-6){r_ir[8]}}, r_ir[8:6], r_ir[2:0]};
      if (i_pl && i_jb)
         w_pc_next = i_a_bus;
      else if (i_pl && w_taken)
         w_pc_next = r_pc + w_offset;
      else
         w_pc_next = r_pc + ADDR_W'(1);
   end

   assign imem.imem_req  = (r_state == S_FETCH);
   assign imem.imem_addr = r_pc;
   assign o_ir           = r_ir;
   assign o_pc           = r_pc;
   assign o_exec_en      = (r_state == S_EXEC);

`ifdef SC_HALT_EN
   assign o_halted = (r_state == S_HALT);
`else
   assign o_halted = 1'b0;
`endif

endmodule

// File: tb/tb_sc_sequencer.sv
// Directed vector bench for sc_sequencer: instruction table plus reset/halt sequences.
module tb_sc_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ir;
   logic        pl, jb, bc, n, z;
   logic [15:0] a_bus;
   logic        exec_en;
   logic [15:0] pc;
   logic        halted;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] cur_pc;
   logic [15:0] cur_ir;

   sc_sequencer_if #(.ADDR_W(16)) imem_bus ();

   sc_sequencer #(.ADDR_W(16), .RESET_PC(16'h0010)) dut (
      .clk       (clk),
      .rst       (rst),
      .imem      (imem_bus.master),
      .o_ir      (ir),
      .i_pl      (pl),
      .i_jb      (jb),
      .i_bc      (bc),
      .i_n       (n),
      .i_z       (z),
      .i_a_bus   (a_bus),
      .o_exec_en (exec_en),
      .o_pc      (pc),
      .o_halted  (halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic        pl;
      logic        jb;
      logic        bc;
      logic        n;
      logic        z;
      logic [15:0] a_bus;
      int          waits;
      logic [15:0] exp_pc;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_junk();
      pl    = 1'($urandom);
      jb    = 1'($urandom);
      bc    = 1'($urandom);
      n     = 1'($urandom);
      z     = 1'($urandom);
      a_bus = 16'($urandom);
   endtask

   // Entered at a falling edge with the DUT in FETCH; leaves at the falling edge of the next FETCH.
   task automatic run_vec(input int idx, input vec_t v);
      $display("vec %0d: pc=%04h instr=%04h pl=%0b jb=%0b bc=%0b n=%0b z=%0b a_bus=%04h waits=%0d exp_pc=%04h",
               idx, cur_pc, v.instr, v.pl, v.jb, v.bc, v.n, v.z, v.a_bus, v.waits, v.exp_pc);
      check("fetch_req", 32'(imem_bus.imem_req), 32'd1);
      check("fetch_addr", 32'(imem_bus.imem_addr), 32'(cur_pc));
      for (int w = 0; w < v.waits; w++) begin
         imem_bus.imem_ack  = 1'b0;
         imem_bus.imem_data = 16'($urandom);
         drive_junk();
         @(negedge clk);
         check("wait_req", 32'(imem_bus.imem_req), 32'd1);
         check("wait_addr", 32'(imem_bus.imem_addr), 32'(cur_pc));
         check("wait_ir", 32'(ir), 32'(cur_ir));
         check("wait_exec", 32'(exec_en), 32'd0);
      end
      imem_bus.imem_ack  = 1'b1;
      imem_bus.imem_data = v.instr;
      @(negedge clk);
      check("exec_en", 32'(exec_en), 32'd1);
      check("exec_ir", 32'(ir), 32'(v.instr));
      check("exec_pc", 32'(pc), 32'(cur_pc));
      check("exec_req", 32'(imem_bus.imem_req), 32'd0);
      pl = v.pl; jb = v.jb; bc = v.bc; n = v.n; z = v.z; a_bus = v.a_bus;
      imem_bus.imem_data = 16'($urandom);
      @(negedge clk);
      check("next_pc", 32'(pc), 32'(v.exp_pc));
      check("post_exec_en", 32'(exec_en), 32'd0);
      check("post_ir", 32'(ir), 32'(v.instr));
      imem_bus.imem_ack = 1'b0;
      drive_junk();
      cur_pc = v.exp_pc;
      cur_ir = v.instr;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t v;
      vecs[0]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'h0011};
      vecs[1]  = '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 3, 16'h0012};
      vecs[2]  = '{16'h4000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 0, 16'h0020};
      vecs[3]  = '{16'h01C6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF, 0, 16'h001E};
      vecs[4]  = '{16'h4000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0020, 1, 16'h0020};
      vecs[5]  = '{16'h01C6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'hBEEF, 0, 16'h0021};
      vecs[6]  = '{16'h0005, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 0, 16'h0026};
      vecs[7]  = '{16'h00C7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 0, 16'h0027};
      vecs[8]  = '{16'h00C7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2, 16'h0046};
      vecs[9]  = '{16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0026};
      vecs[10] = '{16'hABCD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1, 16'hFFFF};
      vecs[11] = '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 0, 16'h0000};
      vecs[12] = '{16'h01C6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'hFFFE};
      vecs[13] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 16'hFFFF};

      rst = 1'b1;
      imem_bus.imem_ack  = 1'b0;
      imem_bus.imem_data = 16'h0000;
      drive_junk();
      repeat (2) @(negedge clk);
      $display("reset: pc=%04h ir=%04h req=%0b exec_en=%0b halted=%0b", pc, ir, imem_bus.imem_req, exec_en, halted);
      check("rst_pc", 32'(pc), 32'h0010);
      check("rst_ir", 32'(ir), 32'h0000);
      check("rst_req", 32'(imem_bus.imem_req), 32'd0);
      check("rst_exec", 32'(exec_en), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);

      // Release with ack already high: the IDLE cycle must ignore it.
      rst = 1'b0;
      imem_bus.imem_ack  = 1'b1;
      imem_bus.imem_data = 16'hDEAD;
      #1;
      check("idle_req", 32'(imem_bus.imem_req), 32'd0);
      check("idle_exec", 32'(exec_en), 32'd0);
      @(negedge clk);
      cur_pc = 16'h0010;
      cur_ir = 16'h0000;
      check("first_fetch_ir", 32'(ir), 32'h0000);

      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

      // Reset during a FETCH wait; the ack then lands in the IDLE cycle after release.
      $display("seq: reset during fetch wait at pc=%04h", cur_pc);
      imem_bus.imem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstf_pc", 32'(pc), 32'h0010);
      check("rstf_ir", 32'(ir), 32'h0000);
      check("rstf_req", 32'(imem_bus.imem_req), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      imem_bus.imem_ack  = 1'b1;
      imem_bus.imem_data = 16'h5555;
      #1;
      check("rstf_idle_req", 32'(imem_bus.imem_req), 32'd0);
      @(negedge clk);
      imem_bus.imem_ack = 1'b0;
      check("rstf_stray_ir", 32'(ir), 32'h0000);
      check("rstf_fetch_req", 32'(imem_bus.imem_req), 32'd1);
      check("rstf_fetch_addr", 32'(imem_bus.imem_addr), 32'h0010);
      @(negedge clk);
      check("rstf_still_fetch", 32'(imem_bus.imem_req), 32'd1);
      check("rstf_ir_hold", 32'(ir), 32'h0000);

      // Reset during EXEC of a jump: no pc update may happen.
      $display("seq: reset during exec of jump to 7777");
      imem_bus.imem_ack  = 1'b1;
      imem_bus.imem_data = 16'h0ABC;
      @(negedge clk);
      check("rste_exec", 32'(exec_en), 32'd1);
      pl = 1'b1; jb = 1'b1; a_bus = 16'h7777;
      rst = 1'b1;
      #1;
      check("rste_pc", 32'(pc), 32'h0010);
      check("rste_ir", 32'(ir), 32'h0000);
      check("rste_exec_off", 32'(exec_en), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      imem_bus.imem_ack = 1'b0;
      @(negedge clk);
      check("rste_pc_after", 32'(pc), 32'h0010);
      check("rste_fetch_req", 32'(imem_bus.imem_req), 32'd1);
      cur_pc = 16'h0010;
      cur_ir = 16'h0000;

      v = '{16'h4000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 0, 16'h0005};
      run_vec(100, v);

`ifdef SC_HALT_EN
      $display("seq: HALT instruction at pc=%04h", cur_pc);
      imem_bus.imem_ack  = 1'b1;
      imem_bus.imem_data = 16'hFFFF;
      @(negedge clk);
      check("halt_exec", 32'(exec_en), 32'd1);
      pl = 1'b1; jb = 1'b1; a_bus = 16'h1234;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check("halt_flag", 32'(halted), 32'd1);
         check("halt_pc", 32'(pc), 32'h0005);
         check("halt_req", 32'(imem_bus.imem_req), 32'd0);
         check("halt_exec_off", 32'(exec_en), 32'd0);
         @(negedge clk);
      end
`else
      v = '{16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 0, 16'h1234};
      run_vec(101, v);
      check("nohalt_flag", 32'(halted), 32'd0);
      check("nohalt_req", 32'(imem_bus.imem_req), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sc_sequencer.md
# sc_sequencer

Fetch/execute sequencer for the Simple Computer. It owns the program counter (PC) and the instruction register (IR), fetches each instruction from instruction memory through a req/ack handshake, and presents IR to the instruction decoder. It qualifies register and memory writes with a one-cycle execute strobe, then selects the next PC: increment, conditional branch, or jump.

## Interface
- ADDR_W, 16, PC and instruction-address width (≥ 6)
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ack  in  1  memory has imem_data valid this cycle
- imem_data  in  16  fetched instruction
- ir  out  16  instruction register, drives decoder `instr`
- pl  in  1  decoded PC load (from decoder)
- jb  in  1  decoded jump/branch select
- bc  in  1  decoded branch condition select
- n  in  1  function-unit negative flag for current instruction
- z  in  1  function-unit zero flag for current instruction
- a_bus  in  ADDR_W  R[SA] value, jump target
- exec_en  out  1  execute strobe; datapath gates RW/MW with it
- pc  out  ADDR_W  program counter
- halted  out  1  halt indicator (only with SC_HALT_EN, else tied 0)

## Operation
- States: IDLE, FETCH, EXEC (+ HALT with SC_HALT_EN). Reset → IDLE.
- IDLE: all strobes 0; unconditionally → FETCH next clock.
- FETCH: imem_req=1, imem_addr=pc; stays until imem_ack=1; on ack cycle ir←imem_data, → EXEC. imem_data ignored when ack=0.
- EXEC: exec_en=1 for exactly one cycle; decoder/datapath act on ir; at end of cycle pc←next_pc, → FETCH.
- next_pc:
  - pl=1, jb=1: a_bus (jump).
  - pl=1, jb=0: taken = bc ? n : z; taken → pc + sext({ir[8:6], ir[2:0]}) (6-bit signed, −32..+31, relative to the branch's own address); not taken → pc+1.
  - pl=0: pc+1.
- All PC arithmetic modulo 2^ADDR_W; wrap at all-ones to 0 and below 0, no flag.
- n, z, a_bus sampled only in the EXEC cycle; ignored elsewhere.
- imem_ack in IDLE/EXEC/HALT ignored.

## Timing
- Reset values: pc=RESET_PC, ir=16'h0000, imem_req=0, exec_en=0, halted=0, state IDLE.
- Reset asserted mid-fetch or mid-EXEC: immediate abort, state/regs to reset values; no pc update; late ack ignored.
- Minimum 3 cycles after reset release to first exec_en (IDLE, FETCH w/ ack, EXEC).
- Steady state: 2 cycles/instruction with zero-wait memory (ack in first FETCH cycle); +1 cycle per wait cycle.
- imem_req and imem_addr are stable throughout a FETCH, including wait cycles.
- ir changes only on the FETCH ack edge; ir is stable throughout EXEC.
- pc changes only on the EXEC→FETCH edge (and on reset).
- exec_en is never high on two consecutive cycles.

## Configuration
- SC_HALT_EN defined: in EXEC, ir==16'hFFFF is HALT. exec_en still pulses; pc is not updated; → HALT. In HALT, imem_req=0, exec_en=0, halted=1, held until reset.
- SC_HALT_EN undefined: 16'hFFFF executes as an ordinary jump (pl=jb=1); no HALT state; halted tied 0.

## Test plan
- Reset with RESET_PC=16'h0010, ack tied 1, all instructions pl=0 → exec_en pulses every 2nd cycle; pc 0x10, 0x11, 0x12; first exec_en is the 3rd cycle after reset release.
- Fetch with 3 wait cycles → imem_req high 4 cycles with addr constant; ir loads only on the ack cycle.
- Branch at pc=0x0020, ir[8:6]=3'b111, ir[2:0]=3'b110 (−2), bc=0, z=1 → pc=0x001E; same instruction with z=0 → pc=0x0021.
- Jump with a_bus=16'hFFFF, then an instruction with pl=0 at 0xFFFF → pc wraps to 0x0000.
- Reset asserted during a FETCH wait, ack arrives 1 cycle after release → state IDLE, ir=0, pc=RESET_PC; stray ack ignored.
- With SC_HALT_EN, fetch 16'hFFFF at pc=0x0005 → one exec_en pulse, halted=1, pc stays 0x0005, imem_req=0 thereafter; without the macro → pc=a_bus.
